// File: rtl/hwce_shift_adder_ctrl.sv
// Pass/beat sequencer that drives the shift-adder base, bias and ReLU selects for one output tile.
// Define HWCE_SA_CTRL_PERF_EN to add the stall_cnt performance counter output.
`timescale 1ns/1ps
module hwce_shift_adder_ctrl #(
    parameter int unsigned PASS_W = 8,
    parameter int unsigned BEAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [PASS_W-1:0] cfg_nb_pass,
    input  logic [BEAT_W-1:0] cfg_nb_beat,
    input  logic              cfg_bias_en,
    input  logic              cfg_relu_en,
    input  logic              sa_valid,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              sum_over_constant,
    output logic              const_zero,
    output logic              rectifier_activ,
    output logic              partial_rd_en,
    output logic [PASS_W-1:0] pass_idx,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              busy,
    output logic              done
`ifdef HWCE_SA_CTRL_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [PASS_W-1:0] nb_pass_q, nb_pass_d;
    logic [BEAT_W-1:0] nb_beat_q, nb_beat_d;
    logic              bias_q, bias_d;
    logic              relu_q, relu_d;

    logic in_run;
    logic start_ok;
    logic accept;
    logic last_beat;
    logic last_pass;
    logic first_pass;

    assign in_run     = (state_q == RUN);
    assign start_ok   = (state_q == IDLE) && start && !abort;
    // abort wins over a beat handshake presented in the same cycle
    assign accept     = in_run && sa_valid && out_ready && !abort;
    assign last_beat  = (beat_q == nb_beat_q - BEAT_W'(1));
    assign last_pass  = (pass_q == nb_pass_q - PASS_W'(1));
    assign first_pass = (pass_q == '0);

    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        beat_d    = beat_q;
        nb_pass_d = nb_pass_q;
        nb_beat_d = nb_beat_q;
        bias_d    = bias_q;
        relu_d    = relu_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    nb_pass_d = cfg_nb_pass;
                    nb_beat_d = cfg_nb_beat;
                    bias_d    = cfg_bias_en;
                    relu_d    = cfg_relu_en;
                    pass_d    = '0;
                    beat_d    = '0;
                    // an empty job still reports completion
                    state_d   = ((cfg_nb_pass != '0) && (cfg_nb_beat != '0)) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (last_beat) begin
                        beat_d = '0;
                        pass_d = pass_q + PASS_W'(1);
                        if (last_pass) begin
                            state_d = DONE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pass_q    <= '0;
            beat_q    <= '0;
            nb_pass_q <= '0;
            nb_beat_q <= '0;
            bias_q    <= 1'b0;
            relu_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            beat_q    <= beat_d;
            nb_pass_q <= nb_pass_d;
            nb_beat_q <= nb_beat_d;
            bias_q    <= bias_d;
            relu_q    <= relu_d;
        end
    end

    assign out_valid         = in_run && sa_valid;
    assign sum_over_constant = in_run && first_pass;
    assign const_zero        = in_run && first_pass && !bias_q;
    assign partial_rd_en     = in_run && !first_pass;
    assign rectifier_activ   = in_run && last_pass && relu_q;
    assign pass_idx          = pass_q;
    assign beat_idx          = beat_q;
    assign busy              = (state_q != IDLE);
    // an abort landing on the DONE cycle suppresses the completion pulse
    assign done              = (state_q == DONE) && !abort;

`ifdef HWCE_SA_CTRL_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_ok) begin
            stall_q <= '0;
        end else if (in_run && sa_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: doc/hwce_shift_adder_ctrl.md
HWCE_SHIFT_ADDER_CTRL -- requirements
Module: hwce_shift_adder_ctrl

Interface
REQ-001 Parameter: PASS_W, default 8, width of the pass counter (input-feature passes per output tile).
REQ-002 Parameter: BEAT_W, default 16, width of the beat counter (NPX-pixel beats per pass).
REQ-003 Port: clk  in  1  clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port: start  in  1  begin a tile job; sampled only in IDLE.
REQ-006 Port: abort  in  1  cancel the current job.
REQ-007 Port: cfg_nb_pass  in  PASS_W  passes per job.
REQ-008 Port: cfg_nb_beat  in  BEAT_W  beats per pass.
REQ-009 Port: cfg_bias_en  in  1  pass 0 adds the bias constant.
REQ-010 Port: cfg_relu_en  in  1  last pass applies the rectifier.
REQ-011 Port: sa_valid  in  1  shift-adder output valid.
REQ-012 Port: out_ready  in  1  downstream accepts the beat.
REQ-013 Port: out_valid  out  1  beat offered downstream (sa_valid while in RUN).
REQ-014 Port: sum_over_constant  out  1  shift-adder base select; 1 selects the constant.
REQ-015 Port: const_zero  out  1  forces the shift-adder constant to 0.
REQ-016 Port: rectifier_activ  out  1  shift-adder ReLU enable.
REQ-017 Port: partial_rd_en  out  1  request the previous partial sum on y_in.
REQ-018 Port: pass_idx  out  PASS_W  current pass.
REQ-019 Port: beat_idx  out  BEAT_W  current beat.
REQ-020 Port: busy  out  1  state is not IDLE.
REQ-021 Port: done  out  1  one-cycle job-complete pulse.

Function
REQ-022 States: IDLE, RUN, DONE.
REQ-023 In IDLE, start=1 latches all cfg_* inputs and clears pass_idx and beat_idx; the state goes to RUN if cfg_nb_pass!=0 and cfg_nb_beat!=0, otherwise to DONE.
REQ-024 A beat is accepted only in RUN, on a cycle with sa_valid=1 and out_ready=1.
REQ-025 On accept, beat_idx increments; at beat_idx==nb_beat-1 it wraps to 0 and pass_idx increments.
REQ-026 An accept with pass_idx==nb_pass-1 and beat_idx==nb_beat-1 moves the state to DONE.
REQ-027 In DONE, done=1 for exactly one cycle and the state returns to IDLE.
REQ-028 In RUN, sum_over_constant=1 when pass_idx==0, otherwise 0.
REQ-029 In RUN, const_zero=1 when pass_idx==0 and the latched bias_en is 0.
REQ-030 In RUN, partial_rd_en=1 when pass_idx!=0.
REQ-031 In RUN, rectifier_activ=1 only when pass_idx==nb_pass-1 and the latched relu_en is 1.
REQ-032 Outside RUN, all control outputs are 0.
REQ-033 The latched cfg values are held for the whole job; cfg changes during RUN have no effect.
REQ-034 start is ignored outside IDLE.
REQ-035 abort=1 in RUN or DONE returns the state to IDLE on the next edge with no done pulse.
REQ-036 abort=1 together with start=1 in IDLE has abort priority: the state stays in IDLE.
REQ-037 All outputs are combinational from registered state; sa_valid→out_valid and ready have zero latency; the block adds no pipeline stage.

Reset
REQ-038 With rst_n=0 at a clock edge: state=IDLE, pass_idx=0, beat_idx=0, latched cfg=0, all outputs 0, including mid-job.

Configuration
REQ-039 Macro HWCE_SA_CTRL_PERF_EN defined: adds port stall_cnt out 32; it counts RUN cycles with sa_valid=1 and out_ready=0, clears on an accepted start, saturates at 0xFFFFFFFF and holds through DONE/IDLE.
REQ-040 Macro HWCE_SA_CTRL_PERF_EN undefined: the stall_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-041 nb_pass=3, nb_beat=4, bias=1, relu=1, sa_valid and out_ready held at 1 → 12 accepts.
  - sum_over_constant=1 on beats 0-3 only.
  - partial_rd_en=1 on beats 4-11.
  - rectifier_activ=1 on beats 8-11.
  - done pulses on cycle 13 after start.
REQ-042 nb_pass=1, nb_beat=2, bias=0 → const_zero=1 and sum_over_constant=1 on both beats; rectifier_activ=0 with relu=0.
REQ-043 out_ready toggles 1,0,1,0 with sa_valid=1 → beat_idx advances only on ready cycles; with the macro defined, stall_cnt equals the number of ready=0 cycles.
REQ-044 nb_beat=0 with start → DONE immediately, done one cycle later, no out_valid.
REQ-045 Assert abort at pass 1 beat 2 → IDLE next cycle, no done; a new start runs a full job from pass 0.
REQ-046 rst_n=0 for one cycle mid-job → all outputs 0 next cycle; start pulse in the same cycle as reset is ignored.
